learning_neuron: RTL and testbench
==================================

Name: learning_neuron

Overview:
- Single trainable neuron with 32 inputs plus a bias input. Computes a registered ReLU output from signed fixed-point weights.
- Consumes an externally computed 64-bit error term each cycle. Updates its weights online by gradient step.
- Emits per-input back-propagated error terms for the upstream layer.
- Sits between an input layer and an error-start stage that derives the error from target minus output.

Parameters:
N_IN, 32, number of data inputs (a bias weight is added, so N_IN+1 weights total)
W, 32, width of inputs, weights, output and back terms (signed two's complement)
FRAC, 4, fractional bits of every fixed-point quantity (0x10 = 1.0)
INIT_WEIGHT, 8, reset value of every weight (0.5)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_vec  input  N_IN x W  signed data inputs; element i is in_vec[i]
backprop_in  input  64  signed error for the currently presented out (target − out convention)
learn_rate  input  W  unsigned learning rate, Q.FRAC (0x10 = 1.0)
bias_in  input  W  signed bias input value, multiplied by weight N_IN
back_vec  output  N_IN x W  signed back-propagated error per input
out  output  W  signed neuron output, always >= 0

Behaviour:
- State: weights w[0..N_IN] (W bits, signed), x_q[0..N_IN-1] and b_q (latched inputs), pre_q (72-bit signed pre-activation), out, back_vec.
- Reset (rst_n low, async, takes effect immediately):
  - every w = INIT_WEIGHT
  - x_q, b_q, pre_q = 0
  - out = 0; every back_vec element = 0
- Each rising edge with rst_n high, all updates are simultaneous and use pre-edge values:
  - x_q <= in_vec, b_q <= bias_in.
  - pre_q <= bias_in*w[N_IN] + sum over i of in_vec[i]*w[i]. Uses a 72-bit signed accumulator with no overflow.
  - out <= 0 if the new pre is <= 0. Otherwise out <= (pre >>> FRAC), saturated to 2^(W-1)-1.
  - delta = (pre_q > 0) ? backprop_in : 0. This is the ReLU derivative, taken from the registered pre_q that produced the current out.
  - back_vec[i] <= sat_W((delta * w[i]) >>> FRAC), using the pre-update weight.
  - w[i] <= sat_W(w[i] + ((learn_rate * delta * x_q[i]) >>> (2*FRAC))).
  - w[N_IN] <= sat_W(w[N_IN] + ((learn_rate * delta * b_q) >>> (2*FRAC))).
- Latency:
  - in_vec to out: 1 cycle.
  - backprop_in to weights and back_vec: 1 cycle.
  - A weight change is visible in out 2 edges after the error is presented, when the input is held.
- Arithmetic:
  - All products are full-precision signed; learn_rate is zero-extended.
  - >>> is an arithmetic shift (floor).
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1].
- Boundaries:
  - pre exactly 0 gives out 0 and delta 0.
  - backprop_in = 0 or learn_rate = 0 freezes the weights.
  - Reset asserted mid-learning discards all learned weights.
  - Inputs are don't-care while rst_n is low.

Test Plan:
- Reset: assert rst_n=0 at any time -> out=0, all back_vec=0 immediately. After release, in_vec[0]=0x10 with rest 0 and bias_in=0 -> out=8 after 1 edge.
- Forward, zero error: in_vec all 0, bias_in=0x10, backprop_in=0 -> pre_q=0x80, out=0x8; weights unchanged over 10 cycles.
- ReLU cut: in_vec[0]=-0x20 with rest 0, bias_in=0, backprop_in=0x10 -> out=0, delta=0, back_vec all 0, weights stay 8.
- Learning step: in_vec[0]=0x10, bias_in=0, learn_rate=0x10, backprop_in=0x10 held.
  - Edge1: out=8.
  - Edge2: w[0]=24, back_vec[0]=8, out=8.
  - Edge3: out=24, w[0]=40, back_vec[0]=24.
- Saturation: all in_vec=0x7FFFFFFF, bias_in=0 -> out=0x7FFFFFFF. A weight driven past 2^31-1 by a large error clamps at 0x7FFFFFFF.
- Async reset mid-learning: after the learning step, pulse rst_n low between edges -> out=0 at once; the next forward pass with in_vec[0]=0x10 gives out=8.

Source files
------------

// File: rtl/learning_neuron.sv
// rtl/learning_neuron.sv - single trainable ReLU neuron with online gradient-step weight update
// Forward pass, error back-propagation and weight update all complete in one clock.
module learning_neuron #(
  parameter int N_IN        = 32,
  parameter int W           = 32,
  parameter int FRAC        = 4,
  parameter int INIT_WEIGHT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IN-1:0][W-1:0]     in_vec,
  input  logic [63:0]                backprop_in,
  input  logic [W-1:0]               learn_rate,
  input  logic [W-1:0]               bias_in,
  output logic [N_IN-1:0][W-1:0]     back_vec,
  output logic [W-1:0]               out
);

  localparam int PW = 72;
  // Wide enough for learn_rate(+sign) * 64-bit error * W-bit input with headroom for the add.
  localparam int UW = W + 1 + 64 + W + 1;

  logic [N_IN:0][W-1:0]   w_q, w_d;
  logic [N_IN-1:0][W-1:0] x_q, x_d;
  logic [W-1:0]           b_q, b_d;
  logic signed [PW-1:0]   pre_q, pre_d;
  logic [W-1:0]           out_q, out_d;
  logic [N_IN-1:0][W-1:0] back_q, back_d;

  logic signed [UW-1:0]   delta;
  logic signed [UW-1:0]   lr_s;

  function automatic logic [W-1:0] sat_w(input logic signed [UW-1:0] v);
    if ((&v[UW-1:W-1]) || ~(|v[UW-1:W-1]))
      return v[W-1:0];
    else if (v[UW-1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  always_comb begin
    x_d   = in_vec;
    b_d   = bias_in;
    pre_d = PW'($signed(bias_in)) * PW'($signed(w_q[N_IN]));
    for (int i = 0; i < N_IN; i++) begin
      pre_d = pre_d + PW'($signed(in_vec[i])) * PW'($signed(w_q[i]));
    end
    out_d = (pre_d > 0) ? sat_w(UW'(pre_d >>> FRAC)) : '0;

    // ReLU derivative comes from the pre-activation that produced the out being judged.
    delta = (pre_q > 0) ? UW'($signed(backprop_in)) : '0;
    lr_s  = {{(UW-W){1'b0}}, learn_rate};

    back_d = '0;
    w_d    = w_q;
    for (int i = 0; i < N_IN; i++) begin
      back_d[i] = sat_w((delta * UW'($signed(w_q[i]))) >>> FRAC);
      w_d[i]    = sat_w(UW'($signed(w_q[i])) +
                        ((lr_s * delta * UW'($signed(x_q[i]))) >>> (2*FRAC)));
    end
    w_d[N_IN] = sat_w(UW'($signed(w_q[N_IN])) +
                      ((lr_s * delta * UW'($signed(b_q))) >>> (2*FRAC)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= N_IN; i++) begin
        w_q[i] <= W'(INIT_WEIGHT);
      end
      x_q    <= '0;
      b_q    <= '0;
      pre_q  <= '0;
      out_q  <= '0;
      back_q <= '0;
    end else begin
      w_q    <= w_d;
      x_q    <= x_d;
      b_q    <= b_d;
      pre_q  <= pre_d;
      out_q  <= out_d;
      back_q <= back_d;
    end
  end

  assign out      = out_q;
  assign back_vec = back_q;

endmodule

// File: tb/tb_learning_neuron.sv
// tb/tb_learning_neuron.sv - bench for learning_neuron: directed table, corner sequences, random vs model
module tb_learning_neuron;

  logic              clk;
  logic              rst_n;
  logic [31:0][31:0] in_vec;
  logic [63:0]       backprop_in;
  logic [31:0]       learn_rate;
  logic [31:0]       bias_in;
  logic [31:0][31:0] back_vec;
  logic [31:0]       out;

  learning_neuron dut (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .backprop_in(backprop_in),
    .learn_rate(learn_rate), .bias_in(bias_in), .back_vec(back_vec), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: real-number style arithmetic on very wide signed values.
  logic signed [31:0] mw [33];
  logic signed [31:0] mx [32];
  logic signed [31:0] mb;
  logic signed [191:0] mpre;
  logic [31:0] mout;
  logic [31:0] mback [32];

  function automatic logic [31:0] sat32(input logic signed [191:0] v);
    if (v > 192'sd2147483647) return 32'h7FFFFFFF;
    if (v < -192'sd2147483648) return 32'h80000000;
    return v[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 33; i++) mw[i] = 32'sd8;
    for (int i = 0; i < 32; i++) begin mx[i] = 0; mback[i] = 0; end
    mb = 0; mpre = 0; mout = 0;
  endtask

  task automatic model_step(input logic [31:0][31:0] iv, input logic [31:0] bi,
                            input logic [63:0] bp, input logic [31:0] lr);
    logic signed [191:0] d, lrw, acc, a, wi, xi;
    logic signed [31:0] nw [33];
    d   = (mpre > 0) ? 192'($signed(bp)) : 192'sd0;
    lrw = {160'b0, lr};
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      a = $signed(iv[i]); wi = mw[i];
      acc = acc + a * wi;
    end
    a = $signed(bi); wi = mw[32];
    acc = acc + a * wi;
    for (int i = 0; i < 32; i++) begin
      wi = mw[i]; xi = mx[i];
      mback[i] = sat32((d * wi) >>> 4);
      nw[i]    = sat32(wi + ((lrw * d * xi) >>> 8));
    end
    wi = mw[32]; xi = mb;
    nw[32] = sat32(wi + ((lrw * d * xi) >>> 8));
    for (int i = 0; i < 33; i++) mw[i] = nw[i];
    for (int i = 0; i < 32; i++) mx[i] = iv[i];
    mb   = bi;
    mpre = acc;
    mout = (acc > 0) ? sat32(acc >>> 4) : 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_out", {32'd0, out}, 64'd0);
    chk("reset_back_zero", {63'd0, |back_vec}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [31:0] in0;
    logic [31:0] bias;
    logic [63:0] bp;
    logic [31:0] lr;
    logic [31:0] exp_out;
    logic [31:0] exp_b0;
    logic [31:0] exp_b1;
  } vec_t;

  vec_t tbl [14];

  initial begin
    rst_n = 1'b0; in_vec = '0; backprop_in = '0; learn_rate = '0; bias_in = '0;
    // Sequential from reset: pre_q==0 gives delta 0, bias forward with frozen weights,
    // pre exactly 0, ReLU cut, then a three-step learning run on w[0].
    tbl[0]  = '{32'h10,       32'h0,  64'h10, 32'h10, 32'd8,  32'd0,  32'd0};
    tbl[1]  = '{32'h0,        32'h10, 64'h0,  32'h10, 32'd8,  32'd0,  32'd0};
    tbl[2]  = '{32'h0,        32'h10, 64'h0,  32'h10, 32'd8,  32'd0,  32'd0};
    tbl[3]  = '{32'h0,        32'h10, 64'h0,  32'h10, 32'd8,  32'd0,  32'd0};
    tbl[4]  = '{32'h0,        32'h10, 64'h0,  32'h10, 32'd8,  32'd0,  32'd0};
    tbl[5]  = '{32'h0,        32'h0,  64'h0,  32'h10, 32'd0,  32'd0,  32'd0};
    tbl[6]  = '{32'h0,        32'h0,  64'h10, 32'h10, 32'd0,  32'd0,  32'd0};
    tbl[7]  = '{32'hFFFFFFE0, 32'h0,  64'h0,  32'h10, 32'd0,  32'd0,  32'd0};
    tbl[8]  = '{32'hFFFFFFE0, 32'h0,  64'h10, 32'h10, 32'd0,  32'd0,  32'd0};
    tbl[9]  = '{32'hFFFFFFE0, 32'h0,  64'h10, 32'h10, 32'd0,  32'd0,  32'd0};
    tbl[10] = '{32'h10,       32'h0,  64'h10, 32'h10, 32'd8,  32'd0,  32'd0};
    tbl[11] = '{32'h10,       32'h0,  64'h10, 32'h10, 32'd8,  32'd8,  32'd8};
    tbl[12] = '{32'h10,       32'h0,  64'h10, 32'h10, 32'd24, 32'd24, 32'd8};
    tbl[13] = '{32'h10,       32'h0,  64'h10, 32'h10, 32'd40, 32'd40, 32'd8};

    #3;
    chk("reset_initial_out", {32'd0, out}, 64'd0);
    do_reset();

    for (int k = 0; k < 14; k++) begin
      in_vec = '0; in_vec[0] = tbl[k].in0;
      bias_in = tbl[k].bias; backprop_in = tbl[k].bp; learn_rate = tbl[k].lr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out", k), {32'd0, out}, {32'd0, tbl[k].exp_out});
      chk($sformatf("tbl%0d_back0", k), {32'd0, back_vec[0]}, {32'd0, tbl[k].exp_b0});
      chk($sformatf("tbl%0d_back1", k), {32'd0, back_vec[1]}, {32'd0, tbl[k].exp_b1});
    end

    // Async reset between edges discards learned w[0]=56.
    #2; rst_n = 1'b0;
    #1;
    chk("async_rst_out", {32'd0, out}, 64'd0);
    chk("async_rst_back", {32'd0, back_vec[0]}, 64'd0);
    #1; rst_n = 1'b1;
    in_vec = '0; in_vec[0] = 32'h10; bias_in = 0; backprop_in = 0; learn_rate = 0;
    @(posedge clk); #1;
    chk("post_rst_out", {32'd0, out}, 64'd8);
    backprop_in = 64'h10; learn_rate = 32'h10;
    @(posedge clk); #1;
    chk("post_rst_back0", {32'd0, back_vec[0]}, 64'd8);
    chk("post_rst_out2", {32'd0, out}, 64'd8);

    // Saturation of out and of a weight.
    do_reset();
    for (int i = 0; i < 32; i++) in_vec[i] = 32'h7FFFFFFF;
    bias_in = 0; backprop_in = 0; learn_rate = 0;
    @(posedge clk); #1;
    chk("sat_out_all_max", {32'd0, out}, 64'h7FFFFFFF);
    in_vec = '0; in_vec[0] = 32'h7FFFFFFF;
    @(posedge clk); #1;
    chk("sat_out_half", {32'd0, out}, 64'h3FFFFFFF);
    backprop_in = 64'h7FFFFFFFFFFFFFFF; learn_rate = 32'h10;
    @(posedge clk); #1;
    chk("sat_back0", {32'd0, back_vec[0]}, 64'h7FFFFFFF);
    chk("sat_out_pre_update", {32'd0, out}, 64'h3FFFFFFF);
    in_vec[0] = 32'h10; backprop_in = 0; learn_rate = 0;
    @(posedge clk); #1;
    chk("sat_weight_clamped", {32'd0, out}, 64'h7FFFFFFF);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      int  v;
      longint b;
      int  bad;
      for (int i = 0; i < 32; i++) begin
        v = int'($urandom_range(511)) - 256;
        in_vec[i] = v;
      end
      v = int'($urandom_range(511)) - 256;
      bias_in = v;
      b = longint'($urandom_range(1023)) - 512;
      if ($urandom_range(3) == 0) b = 0;
      backprop_in = b;
      learn_rate = $urandom_range(32);
      @(posedge clk); #1;
      model_step(in_vec, bias_in, backprop_in, learn_rate);
      chk($sformatf("rand%0d_out", c), {32'd0, out}, {32'd0, mout});
      bad = -1;
      for (int i = 0; i < 32; i++) if (bad < 0 && back_vec[i] !== mback[i]) bad = i;
      if (bad < 0) chk($sformatf("rand%0d_back", c), 64'd0, 64'd0 + {32'd0, back_vec[0]} - {32'd0, mback[0]});
      else chk($sformatf("rand%0d_back%0d", c, bad), {32'd0, back_vec[bad]}, {32'd0, mback[bad]});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
